// File: rtl/arith_mix_pkg.sv
// arith_mix_pkg: shared types, default widths and the XOR-fold helper for arith_mix_pipe
package arith_mix_pkg;

    typedef enum logic {
        MIX_MUL     = 1'b0,
        MIX_MUL_NOT = 1'b1
    } mix_mode_e;

    localparam int DEF_IN_W  = 9;
    localparam int DEF_ACC_W = 24;
    localparam int DEF_OUT_W = 4;

    // Upper bounds for the generic fold; ACC_W <= 64 and OUT_W <= 16 are supported
    localparam int FOLD_ACC_MAX = 64;
    localparam int FOLD_OUT_MAX = 16;

    // Number of OUT_W slices once ACC_W is zero-extended to a multiple of OUT_W
    function automatic int fold_slices(input int acc_w, input int out_w);
        return (acc_w + out_w - 1) / out_w;
    endfunction

    // XOR of all out_w-bit slices of the low acc_w bits of v; missing top bits read as zero
    function automatic logic [FOLD_OUT_MAX-1:0] xor_fold(input logic [FOLD_ACC_MAX-1:0] v,
                                                         input int acc_w, input int out_w,
                                                         input int n_slices);
        logic [FOLD_OUT_MAX-1:0] r;
        r = '0;
        for (int s = 0; s < FOLD_ACC_MAX; s++)
            for (int b = 0; b < FOLD_OUT_MAX; b++)
                if (s < n_slices && b < out_w && s * out_w + b < acc_w)
                    r[b] = r[b] ^ v[s * out_w + b];
        return r;
    endfunction

endpackage

// File: rtl/arith_mix_pipe_stage.sv
// arith_mix_stage: one lockstep pipeline register with valid, enable and flush
module arith_mix_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Flush drops the item regardless of enable; payload is kept, only valid matters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (en) begin
            valid <= in_valid;
            q     <= d;
        end
    end

endmodule

// File: rtl/arith_mix_pipe.sv
// arith_mix_pipe: three-stage XOR/add/OR, multiply, subtract and fold pipeline with handshake
module arith_mix_pipe
    import arith_mix_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  input_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] output_data,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    localparam int W0     = IN_W - 3;
    localparam int FOLD_N = fold_slices(ACC_W, OUT_W);
    localparam int S1_W   = 1 + IN_W + W0;
    localparam int S2_W   = ACC_W + W0;

    logic            stall, en;
    logic [W0-1:0]   a, b, c, t0;
    logic            s1_v, s2_v;
    logic [S1_W-1:0] s1_q;
    logic [S2_W-1:0] s2_q;
    logic            s1_mode;
    logic [IN_W-1:0] s1_in;
    logic [W0-1:0]   s1_t0, s2_t0;
    logic [ACC_W-1:0] p_mul, p, s2_p, r;
    logic [OUT_W-1:0] fold;

    assign stall    = out_valid && !out_ready;
    assign en       = !stall;
    assign in_ready = !stall && !flush;
    assign busy     = s1_v || s2_v || out_valid;

    // S1: overlapping W0-bit windows combined by XOR, add and OR
    always_comb begin
        a  = input_data[IN_W-1 -: W0];
        b  = input_data[IN_W-2 -: W0];
        c  = input_data[IN_W-3 -: W0];
        t0 = ((a ^ b) + b) | c;
    end

    arith_mix_stage #(.W(S1_W)) u_s1 (
        .clk(clk), .rst(rst), .flush(flush), .en(en),
        .in_valid(in_valid && in_ready),
        .d({in_mode, input_data, t0}),
        .valid(s1_v), .q(s1_q)
    );

    assign {s1_mode, s1_in, s1_t0} = s1_q;

    // S2: multiply, optionally adding the complement of t0 for MIX_MUL_NOT
    always_comb begin
        p_mul = ACC_W'(s1_t0) * ACC_W'(s1_in);
        p     = (mix_mode_e'(s1_mode) == MIX_MUL_NOT) ? p_mul + ~ACC_W'(s1_t0) : p_mul;
    end

    arith_mix_stage #(.W(S2_W)) u_s2 (
        .clk(clk), .rst(rst), .flush(flush), .en(en),
        .in_valid(s1_v),
        .d({p, s1_t0}),
        .valid(s2_v), .q(s2_q)
    );

    assign {s2_p, s2_t0} = s2_q;

    // S3: subtract t0 and fold the accumulator down to the output width
    always_comb begin
        r    = s2_p - ACC_W'(s2_t0);
        fold = OUT_W'(xor_fold(FOLD_ACC_MAX'(r), ACC_W, OUT_W, FOLD_N));
    end

    arith_mix_stage #(.W(OUT_W)) u_s3 (
        .clk(clk), .rst(rst), .flush(flush), .en(en),
        .in_valid(s2_v),
        .d(fold),
        .valid(out_valid), .q(output_data)
    );

    // Count completed output handshakes, including one completing during a flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_count <= '0;
        else if (out_valid && out_ready)
            out_count <= out_count + 1'b1;
    end

endmodule
